// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_t : FSM state (IDLE, WAIT)
//   F3_*        : RV32I load/store width codes
package lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load data extraction.
//   rdata  : raw 32-bit word from data memory
//   offset : byte offset of the access within the word
//   funct3 : load width/sign code
//   data   : selected byte/half/word, sign- or zero-extended
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  // Move the addressed lane down to bit 0; halfword offsets are always 0 or 2
  // once alignment has been checked, so the same shift serves both widths.
  logic [31:0] shifted;
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit following the execute ALU.
//   clk, rst            : clock, asynchronous active-high reset
//   ex_*                : instruction from execute (held stable while stall)
//   stall               : combinational pipeline hold
//   mem_req/we/be/addr/wdata, mem_gnt/rvalid/rdata : data memory handshake
//   wb_valid/rd/data    : registered register-file write-back
//   lsu_err             : one-cycle pulse for illegal or misaligned memory ops
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic [2:0]            ex_funct3,
  input  logic [DATA_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic [4:0]            ex_rd,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  lsu_err
);

  lsu_state_t state;

  logic        mem_op;
  logic        alu_op;
  logic        legal_f3;
  logic        illegal;
  logic        misaligned;
  logic        bad_op;
  logic        rd_nz;
  logic [31:0] load_data;

  assign mem_op = ex_valid & (ex_load | ex_store);
  assign alu_op = ex_valid & ~ex_load & ~ex_store;
  assign rd_nz  = |ex_rd;

  always_comb begin
    legal_f3 = 1'b0;
    if (ex_load) begin
      legal_f3 = (ex_funct3 == F3_B)  || (ex_funct3 == F3_H) || (ex_funct3 == F3_W) ||
                 (ex_funct3 == F3_BU) || (ex_funct3 == F3_HU);
    end else if (ex_store) begin
      legal_f3 = (ex_funct3 == F3_B) || (ex_funct3 == F3_H) || (ex_funct3 == F3_W);
    end
  end

  assign illegal    = (ex_load & ex_store) | ~legal_f3;
  assign misaligned = ((ex_funct3[1:0] == 2'b01) & ex_addr[0]) |
                      ((ex_funct3[1:0] == 2'b10) & (|ex_addr[1:0]));
  assign bad_op     = mem_op & (illegal | misaligned);

  // Request is held high in IDLE until granted; WAIT never re-requests.
  assign mem_req = (state == IDLE) & mem_op & ~bad_op;
  assign mem_we  = mem_req & ex_store;
  assign mem_addr = {ex_addr[31:2], 2'b00};

  // A granted store finishes in place; a load always spends at least one
  // cycle waiting for its data, so it stalls even in the grant cycle.
  assign stall = (state == WAIT) ? ~mem_rvalid : (mem_req & (ex_load | ~mem_gnt));

  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << ex_addr[1:0];
        mem_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = 4'b0011 << {ex_addr[1], 1'b0};
        mem_wdata = {2{ex_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = ex_wdata;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (ex_addr[1:0]),
    .funct3 (ex_funct3),
    .data   (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= '0;
      lsu_err  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      lsu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req && mem_gnt && ex_load) begin
            state <= WAIT;
          end
          if (alu_op) begin
            wb_valid <= rd_nz;
            wb_rd    <= ex_rd;
            wb_data  <= ex_addr;
          end
          if (bad_op) begin
            lsu_err <= 1'b1;
          end
        end
        WAIT: begin
          // ex_* is still held by the stall, so rd/funct3/offset are valid here.
          if (mem_rvalid) begin
            state    <= IDLE;
            wb_valid <= rd_nz;
            wb_rd    <= ex_rd;
            wb_data  <= load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a behavioural model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  always #5 clk = ~clk;

  lsu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .lsu_err(lsu_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit model_bad(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a);
    bit legal;
    if (ld && st) return 1'b1;
    if (ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    if (!legal) return 1'b1;
    return (a % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n = size_bytes(f3);
    int m = ((1 << n) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (size_bytes(f3))
      1:       return (d & 32'hFF) * 32'h01010101;
      2:       return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd_word);
    int          bits = 8 * size_bytes(f3);
    logic [31:0] v    = rd_word >> (8 * (a % 4));
    logic [31:0] mask;
    if (bits >= 32) return v;
    mask = (32'd1 << bits) - 32'd1;
    v = v & mask;
    if (f3 < 4 && ((v >> (bits - 1)) & 32'd1) == 32'd1) v = v | ~mask;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic go_idle();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // Called and returns at posedge+1. Runs one instruction to completion.
  task automatic do_txn(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rword);
    bit mem = ld || st;
    bit bad = mem && model_bad(ld, st, f3, addr);
    n_txn++;
    $display("[TB] txn %0d ld=%0b st=%0b f3=%0d addr=0x%08h rd=%0d gnt_dly=%0d rv_dly=%0d",
             n_txn, ld, st, f3, addr, rd, gnt_dly, rv_dly);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_rd = rd;
    if (!mem || bad) begin
      mem_gnt = 1'($urandom % 2); mem_rvalid = 1'b0;
      #4;
      check("nomem_stall", 32'(stall), 32'd0);
      check("nomem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
      go_idle();
      check("err", 32'(lsu_err), 32'(bad));
      check("nomem_wbv", 32'(wb_valid), 32'(!mem && rd != 0));
      if (!mem && rd != 0) begin
        check("alu_rd", 32'(wb_rd), 32'(rd));
        check("alu_data", wb_data, addr);
      end
      if (bad) begin
        @(posedge clk); #1;
        check("err_pulse", 32'(lsu_err), 32'd0);
      end
    end else begin
      for (int c = 0; c <= gnt_dly; c++) begin
        mem_gnt = (c == gnt_dly); mem_rvalid = 1'b0;
        #4;
        check("req", 32'(mem_req), 32'd1);
        check("we", 32'(mem_we), 32'(st));
        check("addr", mem_addr, addr & ~32'd3);
        check("be", 32'(mem_be), 32'(model_be(f3, addr)));
        if (st) check("wdata", mem_wdata, model_wdata(f3, wd));
        check("req_stall", 32'(stall), 32'(ld || c < gnt_dly));
        @(posedge clk); #1;
      end
      if (ld) begin
        for (int c = 1; c <= rv_dly; c++) begin
          mem_gnt = 1'b0; mem_rvalid = (c == rv_dly);
          mem_rdata = (c == rv_dly) ? rword : $urandom;
          #4;
          check("wait_req", 32'(mem_req), 32'd0);
          check("wait_stall", 32'(stall), 32'(c != rv_dly));
          @(posedge clk); #1;
        end
      end
      go_idle();
      check("mem_wbv", 32'(wb_valid), 32'(ld && rd != 0));
      check("mem_err", 32'(lsu_err), 32'd0);
      if (ld && rd != 0) begin
        check("ld_rd", 32'(wb_rd), 32'(rd));
        check("ld_data", wb_data, model_load(f3, addr, rword));
      end
    end
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit          ld, st;
    int          kind;

    rst = 1'b1;
    go_idle();
    ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wbrd", 32'(wb_rd), 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_err", 32'(lsu_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the test plan
    do_txn(0, 0, 3'd0, 32'h1234, 32'd0, 5'd5, 0, 1, 32'd0);
    do_txn(0, 1, 3'd0, 32'h103, 32'hAB, 5'd3, 0, 1, 32'd0);
    do_txn(1, 0, 3'd0, 32'h202, 32'd0, 5'd6, 2, 1, 32'h00800000);
    check("lb_value", wb_data, 32'hFFFFFF80);
    do_txn(1, 0, 3'd4, 32'h202, 32'd0, 5'd6, 0, 1, 32'h00800000);
    check("lbu_value", wb_data, 32'h00000080);
    do_txn(1, 0, 3'd2, 32'h301, 32'd0, 5'd8, 0, 1, 32'd0);
    do_txn(1, 0, 3'd1, 32'h402, 32'd0, 5'd0, 1, 2, 32'h7FFF0000);

    // Reset while a load is outstanding
    do_txn(0, 0, 3'd0, 32'hCAFE, 32'd0, 5'd7, 0, 1, 32'd0);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'd2;
    ex_addr = 32'h500; ex_rd = 5'd9; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #1;
    check("wait_before_rst", 32'(stall), 32'd1);
    go_idle();
    rst = 1'b1;
    #1;
    check("arst_wbrd", 32'(wb_rd), 32'd0);
    check("arst_wbdata", wb_data, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    #4;
    check("stale_rv_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    go_idle();
    check("stale_rv_wbv", 32'(wb_valid), 32'd0);
    check("stale_rv_data", wb_data, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom % 5);
      ld = (kind == 1 || kind == 2);
      st = (kind == 3 || kind == 4);
      if (kind != 0 && ($urandom % 8) == 0) begin ld = 1; st = 1; end
      f3 = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom % 3);
      if (ld && !st && ($urandom % 3 == 0)) f3 = 3'd4 + 3'($urandom % 2);
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      do_txn(ld, st, f3, a, $urandom, 5'($urandom), int'($urandom % 4),
             1 + int'($urandom % 3), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the execute ALU. It consumes the ALU result as a data address (or passes it through as a write-back value) and issues byte/half/word requests to data memory over a req/gnt/rvalid handshake. It stalls the upstream pipeline while a memory transaction is outstanding, and produces a registered write-back stream for the register file.

## Interface
- `DATA_WIDTH`, default 32: datapath width; only 32 is supported.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `ex_valid`, input, 1: execute stage holds a valid instruction.
- `ex_load`, input, 1: instruction is a load.
- `ex_store`, input, 1: instruction is a store.
- `ex_funct3`, input, 3: RV32I load/store width code.
- `ex_addr`, input, 32: ALU result; the address for memory ops, the result value otherwise.
- `ex_wdata`, input, 32: store data (rs2).
- `ex_rd`, input, 5: destination register.
- `stall`, output, 1: combinational; execute must hold all `ex_*` stable while high.
- `mem_req`, output, 1: memory request.
- `mem_we`, output, 1: request is a write.
- `mem_be`, output, 4: byte enables.
- `mem_addr`, output, 32: word-aligned address, `{ex_addr[31:2],2'b00}`.
- `mem_wdata`, output, 32: lane-replicated store data.
- `mem_gnt`, input, 1: request accepted this cycle.
- `mem_rvalid`, input, 1: read data valid.
- `mem_rdata`, input, 32: read word.
- `wb_valid`, output, 1: registered write-back strobe.
- `wb_rd`, output, 5: registered destination register.
- `wb_data`, output, 32: registered write-back data.
- `lsu_err`, output, 1: registered one-cycle pulse flagging a misaligned or illegal memory op.

## Operation
- **Definitions.**
  - mem_op = `ex_valid & (ex_load | ex_store)`.
  - illegal = `ex_load & ex_store`, or a funct3 outside the legal set for the op.
    - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Store funct3: 000 SB, 001 SH, 010 SW.
  - misaligned = a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`.
- **States.** IDLE and WAIT.
- **IDLE, mem_op, not illegal and not misaligned.**
  - `mem_req=1` combinationally from the `ex_*` fields.
  - `mem_we=ex_store`.
- **IDLE, request granted.**
  - Store with `mem_gnt=1`: complete; `stall=0`; remain in IDLE.
  - Load with `mem_gnt=1`: `stall=1`; go to WAIT.
- **IDLE, request not granted.** `mem_gnt=0`: `stall=1`; remain in IDLE; `mem_req` stays high.
- **WAIT.**
  - `mem_req=0`.
  - `stall=1` until `mem_rvalid`.
  - In the `mem_rvalid` cycle: `stall=0`, load data captured into the write-back registers, go to IDLE.
- **Byte enables and store data.**
  - Byte: `be=4'b0001<<addr[1:0]`; wdata = byte replicated ×4.
  - Half: `be=4'b0011<<{addr[1],1'b0}`; wdata = half replicated ×2.
  - Word: `be=4'b1111`; wdata = `ex_wdata`.
- **Load extraction.**
  - Select the byte or half from `mem_rdata` using `addr[1:0]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- **Non-memory op.** `ex_valid` with no load or store: `wb_data<=ex_addr` and `wb_rd<=ex_rd` on the next edge.
- **`wb_valid` rule.** `wb_valid<=1` only for an ALU pass-through or a completed load, and only when `ex_rd≠0`. Stores never write back.
- **Illegal or misaligned op.**
  - No `mem_req` and no stall.
  - `lsu_err<=1` for one cycle; `wb_valid<=0`.
- **Reset.**
  - All registered outputs reset to 0 (`wb_valid`, `wb_rd`, `wb_data`, `lsu_err`); state resets to IDLE.
  - Reset in WAIT abandons the load; a later `mem_rvalid` in IDLE is ignored.

## Timing
- ALU pass-through: 1-cycle latency, no stall.
- Store with `mem_gnt` in the first cycle: 0 stall cycles.
  - Each cycle without `mem_gnt` adds 1 stall cycle.
- Load: the memory must not assert `mem_rvalid` in the grant cycle.
  - Minimum: grant in cycle 0, `mem_rvalid` in cycle 1, `wb_valid` in cycle 2; 1 stall cycle.
- Each `mem_rvalid` in WAIT completes exactly one load. There is at most one outstanding request.
- `stall` depends combinationally on `mem_gnt` and `mem_rvalid`. Upstream registers it as an enable only, never as a data path.

## Structure
- `lsu_pkg` contains:
  - the state enum `lsu_state_t` (IDLE, WAIT);
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- Sub-module `lsu_load_align` is combinational: inputs `rdata`, `offset[1:0]` and `funct3`; output is the extended 32-bit value.
- The store lane and byte-enable logic and the FSM stay in `lsu`.

## Test plan
- **ALU pass-through.** `ex_addr=0x1234`, `rd=5`, no mem op → next cycle `wb_valid=1`, `wb_rd=5`, `wb_data=0x1234`, `stall=0` throughout.
- **SB with immediate grant.** `addr=0x103`, `wdata=0xAB`, `gnt` immediate → `mem_be=1000`, `mem_addr=0x100`, `mem_wdata=0xABABABAB`, no stall, no `wb_valid`.
- **LB with delayed grant.** `addr=0x202`, `gnt` delayed 2 cycles, `rvalid` 1 cycle after grant, `rdata=0x00800000` → 3 stall cycles, then `wb_data=0xFFFFFF80`. LBU on the same data gives `wb_data=0x00000080`.
- **Misaligned LW.** `addr=0x301` → no `mem_req`, `stall=0`, `lsu_err` pulses for 1 cycle, `wb_valid=0`.
- **Load to x0.** LH, `rd=0`, `addr=0x402`, `rdata=0x7FFF0000` → transaction completes, `wb_valid` stays 0.
- **Reset in WAIT.** Assert `rst` while in WAIT → all outputs 0 immediately; a later `rvalid` produces no `wb_valid`.
